// File: rtl/polilock_tentativas_ctrl.sv
// Polilock attempt sequencer: compares received UART bytes with the stored password,
// pulses acertou/errou, counts consecutive failures and enforces a timed lockout.
module polilock_tentativas_ctrl #(
  parameter int SENHA_LEN      = 10,
  parameter int MAX_TENTATIVAS = 3,
  parameter int BLOQ_CICLOS    = 1_500_000_000,
  parameter int TIMEOUT_CICLOS = 500_000_000,
  localparam int AW = (SENHA_LEN > 1) ? $clog2(SENHA_LEN) : 1,
  localparam int TW = $clog2(MAX_TENTATIVAS + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          iniciar,
  input  logic          rx_valid,
  input  logic [7:0]    rx_dado,
  input  logic [7:0]    mem_dado,
  output logic [AW-1:0] mem_endereco,
  output logic          acertou,
  output logic          errou,
  output logic          bloqueado,
  output logic [TW-1:0] db_tentativas,
  output logic [3:0]    db_estado
);

  localparam int TMO_W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam int BLQ_W = (BLOQ_CICLOS > 1) ? $clog2(BLOQ_CICLOS) : 1;
  localparam int CW    = (TMO_W > BLQ_W) ? TMO_W : BLQ_W;

  localparam logic [AW-1:0] CNT_LAST     = AW'(SENHA_LEN - 1);
  localparam logic [TW-1:0] TENT_MAX     = TW'(MAX_TENTATIVAS);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CICLOS - 1);
  localparam logic [CW-1:0] BLOQ_LAST    = CW'(BLOQ_CICLOS - 1);

  typedef enum logic [3:0] {
    OCIOSO    = 4'd0,
    ESPERA    = 4'd1,
    COMPARA   = 4'd2,
    FIM       = 4'd3,
    ACERTOU   = 4'd4,
    ERROU     = 4'd5,
    BLOQUEADO = 4'd6
  } estado_t;

  estado_t       estado;
  logic [AW-1:0] char_cnt;
  logic          mismatch;
  logic [TW-1:0] tentativas;
  logic [TW-1:0] tent_inc;
  logic [CW-1:0] timer;
  logic [7:0]    byte_rx;

  // One shared timer: it measures the inter-byte gap in ESPERA and the lockout in BLOQUEADO.
  assign tent_inc      = (tentativas == TENT_MAX) ? tentativas : tentativas + 1'b1;
  assign mem_endereco  = char_cnt;
  assign db_tentativas = tentativas;
  assign db_estado     = estado;

  // acertou/errou are set on the edge that enters their state, so each lasts exactly one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado     <= OCIOSO;
      char_cnt   <= '0;
      mismatch   <= 1'b0;
      tentativas <= '0;
      timer      <= '0;
      byte_rx    <= '0;
      acertou    <= 1'b0;
      errou      <= 1'b0;
      bloqueado  <= 1'b0;
    end else begin
      acertou <= 1'b0;
      errou   <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (iniciar) begin
            estado   <= ESPERA;
            char_cnt <= '0;
            mismatch <= 1'b0;
            timer    <= '0;
          end
        end
        ESPERA: begin
          if (rx_valid) begin
            byte_rx <= rx_dado;
            estado  <= COMPARA;
          end else if (timer == TIMEOUT_LAST) begin
            estado <= ERROU;
            errou  <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        COMPARA: begin
          // A wrong byte is remembered, but the remaining bytes are still consumed.
          if (byte_rx != mem_dado) begin
            mismatch <= 1'b1;
          end
          if (char_cnt == CNT_LAST) begin
            estado <= FIM;
          end else begin
            char_cnt <= char_cnt + 1'b1;
            timer    <= '0;
            estado   <= ESPERA;
          end
        end
        FIM: begin
          if (mismatch) begin
            estado <= ERROU;
            errou  <= 1'b1;
          end else begin
            estado  <= ACERTOU;
            acertou <= 1'b1;
          end
        end
        ACERTOU: begin
          tentativas <= '0;
          estado     <= OCIOSO;
        end
        ERROU: begin
          tentativas <= tent_inc;
          timer      <= '0;
          if (tent_inc == TENT_MAX) begin
            estado    <= BLOQUEADO;
            bloqueado <= 1'b1;
          end else begin
            estado <= OCIOSO;
          end
        end
        BLOQUEADO: begin
          if (timer == BLOQ_LAST) begin
            tentativas <= '0;
            bloqueado  <= 1'b0;
            estado     <= OCIOSO;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          estado <= OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_polilock_tentativas_ctrl.sv
// Randomised scoreboard bench for polilock_tentativas_ctrl: attempts are scored by a
// word-level password model, pulses are checked by an independent monitor process.
module tb_polilock_tentativas_ctrl;

  localparam int SENHA_LEN = 4;
  localparam int MAX_T     = 3;
  localparam int BLOQ      = 100;
  localparam int TMO       = 50;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_dado = 8'h00;
  logic [7:0] mem_dado;
  logic [1:0] mem_endereco;
  logic       acertou;
  logic       errou;
  logic       bloqueado;
  logic [1:0] db_tentativas;
  logic [3:0] db_estado;

  logic [31:0] senha_w = "ABCD";

  typedef struct {
    bit ok;
    int when;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   model_tent = 0;

  polilock_tentativas_ctrl #(
    .SENHA_LEN(SENHA_LEN),
    .MAX_TENTATIVAS(MAX_T),
    .BLOQ_CICLOS(BLOQ),
    .TIMEOUT_CICLOS(TMO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .iniciar(iniciar),
    .rx_valid(rx_valid),
    .rx_dado(rx_dado),
    .mem_dado(mem_dado),
    .mem_endereco(mem_endereco),
    .acertou(acertou),
    .errou(errou),
    .bloqueado(bloqueado),
    .db_tentativas(db_tentativas),
    .db_estado(db_estado)
  );

  // Password ROM with combinational read.
  assign mem_dado = senha_w[31 - 8*mem_endereco -: 8];

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: every acertou/errou pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (acertou || errou) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_pulse: got acertou=%0b errou=%0b, expected none (cycle %0d)",
                 acertou, errou, cyc);
      end else begin
        mon_e = sb.pop_front();
        check_output("pulse_acertou", int'(acertou), int'(mon_e.ok));
        check_output("pulse_errou", int'(errou), int'(!mon_e.ok));
        check_output("pulse_cycle", cyc, mon_e.when);
      end
    end
  end

  task automatic idle_tick();
    @(negedge clock);
    iniciar  = 1'b0;
    rx_valid = 1'b0;
  endtask

  // Runs one attempt. Byte long_idx waits the longest gap still inside the timeout window.
  task automatic do_attempt(input logic [31:0] w, input int nbytes, input int long_idx);
    int   last_n;
    int   g;
    bit   ok;
    bit   lock;
    exp_t e;
    idle_tick();
    iniciar = 1'b1;
    last_n  = cyc;
    for (int i = 0; i < nbytes; i++) begin
      g = (i == long_idx) ? TMO - 1 : int'($urandom_range(0, 4));
      if (i > 0) g = g + 1;
      repeat (g) idle_tick();
      idle_tick();
      rx_valid = 1'b1;
      rx_dado  = w[31 - 8*i -: 8];
      last_n   = cyc;
    end
    if (nbytes == SENHA_LEN) begin
      ok     = (w == senha_w);
      e.when = last_n + 3;
    end else begin
      ok     = 1'b0;
      e.when = last_n + 2 + TMO;
    end
    e.ok = ok;
    sb.push_back(e);
    while (cyc < e.when + 1) idle_tick();
    check_output("pulse_seen_pending", sb.size(), 0);
    sb.delete();
    model_tent = ok ? 0 : model_tent + 1;
    lock = (model_tent == MAX_T);
    check_output("tentativas_after", int'(db_tentativas), model_tent);
    check_output("estado_after", int'(db_estado), lock ? 6 : 0);
    check_output("bloqueado_after", int'(bloqueado), int'(lock));
    if (lock) begin
      for (int k = 0; k < BLOQ - 1; k++) begin
        idle_tick();
        iniciar  = 1'($urandom_range(0, 1));
        rx_valid = 1'($urandom_range(0, 1));
        rx_dado  = 8'($urandom);
        if (bloqueado !== 1'b1) check_output("bloqueado_hold", int'(bloqueado), 1);
      end
      checks++;
      idle_tick();
      model_tent = 0;
      check_output("bloqueado_end", int'(bloqueado), 0);
      check_output("estado_unlock", int'(db_estado), 0);
      check_output("tentativas_unlock", int'(db_tentativas), 0);
    end
  endtask

  initial begin
    logic [31:0] w;
    logic [7:0]  b;
    int          nb;

    #1 reset = 1'b0;
    #2;
    check_output("reset_estado", int'(db_estado), 0);
    check_output("reset_acertou", int'(acertou), 0);
    check_output("reset_errou", int'(errou), 0);
    check_output("reset_bloqueado", int'(bloqueado), 0);
    check_output("reset_tentativas", int'(db_tentativas), 0);
    check_output("reset_endereco", int'(mem_endereco), 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    do_attempt("ABCD", 4, -1);
    do_attempt("ABXD", 4, -1);

    // Partial attempt aborted by an asynchronous reset in the middle of a cycle.
    idle_tick();
    iniciar = 1'b1;
    idle_tick();
    rx_valid = 1'b1;
    rx_dado  = "A";
    repeat (2) idle_tick();
    rx_valid = 1'b1;
    rx_dado  = "B";
    repeat (2) idle_tick();
    check_output("mid_estado", int'(db_estado), 1);
    check_output("mid_endereco", int'(mem_endereco), 2);
    check_output("mid_tentativas", int'(db_tentativas), 1);
    #2 reset = 1'b0;
    #1;
    check_output("async_estado", int'(db_estado), 0);
    check_output("async_tentativas", int'(db_tentativas), 0);
    check_output("async_endereco", int'(mem_endereco), 0);
    check_output("async_outputs", int'({acertou, errou, bloqueado}), 0);
    @(negedge clock);
    reset      = 1'b1;
    model_tent = 0;

    repeat (3) do_attempt("vVER", 4, -1);

    do_attempt("ABCD", 2, -1);
    do_attempt("ABCD", 4, 2);
    do_attempt("ABCD", 4, 0);

    do_attempt("ABCE", 4, -1);
    do_attempt("ZBCD", 4, 1);
    do_attempt("ABCD", 4, -1);
    idle_tick();
    rx_valid = 1'b1;
    rx_dado  = "A";
    repeat (3) idle_tick();
    check_output("extra_byte_estado", int'(db_estado), 0);

    for (int t = 0; t < 24; t++) begin
      w = senha_w;
      for (int i = 0; i < SENHA_LEN; i++) begin
        b = w[31 - 8*i -: 8];
        if ($urandom_range(0, 9) < 2) b = 8'($urandom_range(8'h30, 8'h7a));
        w[31 - 8*i -: 8] = b;
      end
      nb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, SENHA_LEN - 1)) : SENHA_LEN;
      do_attempt(w, nb, ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, SENHA_LEN - 1)) : -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
